// File: rtl/paged_frame_buffer.sv
// Paged 1 bpp column-major frame buffer. The display port reads the front page,
// the draw engine edits the back page; FLIP swaps which page is shown.
module paged_frame_buffer #(
  parameter int WIDTH         = 128,
  parameter int HEIGHT        = 64,
  parameter int PAGES         = 2,
  parameter int CLEAR_ON_READ = 1,
  localparam int DEPTH = WIDTH * HEIGHT / 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int XW    = $clog2(WIDTH),
  localparam int YW    = $clog2(HEIGHT),
  localparam int PW    = $clog2(PAGES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          disp_req_i,
  input  logic [AW-1:0] disp_addr_i,
  output logic [7:0]    disp_data_o,
  output logic          disp_valid_o,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [2:0]    cmd_op_i,
  input  logic [XW-1:0] cmd_x_i,
  input  logic [YW-1:0] cmd_y_i,
  input  logic [7:0]    cmd_data_i,
  output logic [PW-1:0] front_page_o,
  output logic          busy_o
);

  localparam logic [2:0] OP_SET  = 3'd0;
  localparam logic [2:0] OP_CLR  = 3'd1;
  localparam logic [2:0] OP_TOG  = 3'd2;
  localparam logic [2:0] OP_WORD = 3'd3;
  localparam logic [2:0] OP_FILL = 3'd4;
  localparam logic [2:0] OP_FLIP = 3'd5;
  localparam logic [2:0] OP_NOP  = 3'd6;

  localparam logic [AW-1:0] BYTES_PER_COL = AW'(HEIGHT / 8);
  localparam logic [AW-1:0] LAST_ADDR     = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_L       = (AW+1)'(DEPTH);
  localparam logic [XW:0]   WIDTH_L       = (XW+1)'(WIDTH);
  localparam logic [YW:0]   HEIGHT_L      = (YW+1)'(HEIGHT);

  typedef enum logic [1:0] {ST_IDLE, ST_RMW, ST_FILL} state_t;

  state_t        state_q;
  logic [PW-1:0] front_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] fill_cnt_q;
  logic [2:0]    bit_q;
  logic [2:0]    op_q;
  logic          oob_q;
  logic [7:0]    pat_q;
  logic          disp_valid_q;
  logic          disp_hit_q;
  logic [7:0]    rd_a_q;
  logic [7:0]    rd_b_q;

  // Address space is padded to a power of two per page so {page, addr} indexes directly.
  logic [7:0] mem [PAGES * (2**AW)];

  logic [PW-1:0] back_page;
  logic [AW-1:0] cmd_addr;
  logic          cmd_in_range;
  logic          disp_in_range;
  logic          a_we;
  logic          b_re;
  logic          b_we;
  logic [AW-1:0] b_addr_d;
  logic [7:0]    b_wdata_d;
  logic [7:0]    bit_mask;

  assign back_page     = front_q + PW'(1);
  assign cmd_addr      = AW'(cmd_x_i) * BYTES_PER_COL + AW'(cmd_y_i[YW-1:3]);
  assign cmd_in_range  = ({1'b0, cmd_x_i} < WIDTH_L) && ({1'b0, cmd_y_i} < HEIGHT_L);
  assign disp_in_range = {1'b0, disp_addr_i} < DEPTH_L;
  assign a_we          = disp_req_i && disp_in_range && (CLEAR_ON_READ != 0) && !reset;
  assign bit_mask      = 8'h01 << bit_q;

  always_comb begin
    b_re      = 1'b0;
    b_we      = 1'b0;
    b_addr_d  = addr_q;
    b_wdata_d = rd_b_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          b_addr_d = cmd_addr;
          if (cmd_op_i == OP_WORD) begin
            b_we      = cmd_in_range;
            b_wdata_d = cmd_data_i;
          end else if (cmd_op_i <= OP_TOG) begin
            b_re = 1'b1;
          end
        end
      end
      ST_RMW: begin
        b_we = !oob_q;
        case (op_q)
          OP_SET:  b_wdata_d = rd_b_q | bit_mask;
          OP_CLR:  b_wdata_d = rd_b_q & ~bit_mask;
          default: b_wdata_d = rd_b_q ^ bit_mask;
        endcase
      end
      ST_FILL: begin
        b_we      = 1'b1;
        b_addr_d  = fill_cnt_q;
        b_wdata_d = pat_q;
      end
      default: ;
    endcase
    // A reset cycle aborts whatever write was in flight.
    if (reset) b_we = 1'b0;
  end

  // Port A touches only the front page, port B only the back page, so they never collide.
  always_ff @(posedge clk) begin
    if (b_re) rd_b_q <= mem[{back_page, b_addr_d}];
    if (b_we) mem[{back_page, b_addr_d}] <= b_wdata_d;
    if (disp_req_i) rd_a_q <= mem[{front_q, disp_addr_i}];
    if (a_we) mem[{front_q, disp_addr_i}] <= 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_valid_q <= 1'b0;
      disp_hit_q   <= 1'b0;
    end else begin
      disp_valid_q <= disp_req_i;
      disp_hit_q   <= disp_req_i && disp_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      front_q    <= '0;
      addr_q     <= '0;
      fill_cnt_q <= '0;
      bit_q      <= '0;
      op_q       <= OP_NOP;
      oob_q      <= 1'b0;
      pat_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            case (cmd_op_i)
              OP_SET, OP_CLR, OP_TOG: begin
                addr_q  <= cmd_addr;
                bit_q   <= cmd_y_i[2:0];
                op_q    <= cmd_op_i;
                oob_q   <= !cmd_in_range;
                state_q <= ST_RMW;
              end
              OP_FILL: begin
                pat_q      <= cmd_data_i;
                fill_cnt_q <= '0;
                state_q    <= ST_FILL;
              end
              OP_FLIP: front_q <= back_page;
              default: ;
            endcase
          end
        end
        ST_RMW: state_q <= ST_IDLE;
        ST_FILL: begin
          if (fill_cnt_q == LAST_ADDR) begin
            fill_cnt_q <= '0;
            state_q    <= ST_IDLE;
          end else begin
            fill_cnt_q <= fill_cnt_q + AW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign disp_data_o  = disp_hit_q ? rd_a_q : 8'h00;
  assign disp_valid_o = disp_valid_q;
  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign front_page_o = front_q;

endmodule
